// File: rtl/match_referee.sv
// ---------------------------------------------------------------------------
// match_referee
//   Issues the match-flow requests to the game controller. It uses the
//   keyboard start key, both players' HP and a per-frame round timer to
//   decide when to ask for each transition. It also drives the round
//   countdown and the winner code shown by the HUD/KO renderers.
//   The controller's game_state is the acknowledge for every request.
//
// Ports
//   Clk           system clock
//   Reset         synchronous, active-high reset
//   frame_tick    one-cycle pulse per video frame
//   keycode       current keyboard keycode (0 = none)
//   hp1, hp2      player HP, unsigned
//   game_state    controller state: 0 start, 1 game, 2 gameover, 3 = start
//   game_start    level request start -> game
//   game_over     level request game -> gameover
//   game_restart  level request gameover -> game
//   round_time    seconds remaining in the round
//   winner        0 none, 1 P1, 2 P2, 3 draw
// ---------------------------------------------------------------------------
module match_referee #(
    parameter int          ROUND_SECONDS       = 60,
    parameter int          FRAMES_PER_SEC      = 60,
    parameter int          RESTART_LOCK_FRAMES = 120,
    parameter logic [7:0]  START_KEY           = 8'h28
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    input  logic [7:0] hp1,
    input  logic [7:0] hp2,
    input  logic [1:0] game_state,
    output logic       game_start,
    output logic       game_over,
    output logic       game_restart,
    output logic [6:0] round_time,
    output logic [1:0] winner
);

    localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int LW = (RESTART_LOCK_FRAMES > 0) ? $clog2(RESTART_LOCK_FRAMES + 1) : 1;

    localparam logic [6:0]    ROUND_INIT = 7'(ROUND_SECONDS);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
    localparam logic [LW-1:0] LOCK_INIT  = LW'(RESTART_LOCK_FRAMES);
    localparam logic [LW-1:0] LOCK_ZERO  = LW'(0);
    localparam logic [LW-1:0] LOCK_ONE   = LW'(1);
    localparam logic [FW-1:0] FRAME_ZERO = FW'(0);
    localparam logic [FW-1:0] FRAME_ONE  = FW'(1);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_START_REQ   = 3'd1,
        ST_FIGHT       = 3'd2,
        ST_OVER_REQ    = 3'd3,
        ST_LOCKOUT     = 3'd4,
        ST_READY       = 3'd5,
        ST_RESTART_REQ = 3'd6
    } state_t;

    state_t          state_r;
    logic [FW-1:0]   frame_cnt_r;
    logic [LW-1:0]   lockout_r;
    logic            key_prev_r;

    logic            key_match_s;
    logic            key_hit_s;
    logic            gs_start_s;
    logic            gs_game_s;
    logic            gs_over_s;
    logic            frame_wrap_s;
    logic [6:0]      rt_dec_s;
    logic [6:0]      rt_next_s;
    logic            ko_s;
    logic            round_end_s;
    logic [1:0]      end_winner_s;

    // Winner when at least one player is out of HP.
    function automatic logic [1:0] ko_winner(input logic [7:0] a, input logic [7:0] b);
        logic [1:0] w;
        if ((a == 8'd0) && (b == 8'd0)) begin
            w = 2'd3;
        end else if (a == 8'd0) begin
            w = 2'd2;
        end else begin
            w = 2'd1;
        end
        return w;
    endfunction

    // Winner on timeout: larger HP wins, equal HP is a draw.
    function automatic logic [1:0] timeout_winner(input logic [7:0] a, input logic [7:0] b);
        logic [1:0] w;
        if (a > b) begin
            w = 2'd1;
        end else if (b > a) begin
            w = 2'd2;
        end else begin
            w = 2'd3;
        end
        return w;
    endfunction

    assign key_match_s = (keycode == START_KEY);
    assign key_hit_s   = key_match_s & ~key_prev_r;
    // Reserved state 3 is treated like start.
    assign gs_start_s  = (game_state == 2'd0) || (game_state == 2'd3);
    assign gs_game_s   = (game_state == 2'd1);
    assign gs_over_s   = (game_state == 2'd2);

    // Countdown step and round-end decision for the current frame_tick.
    // The end check looks at round_time as it will be after this tick's
    // decrement, so the tick that empties the clock also ends the round.
    always_comb begin
        rt_dec_s     = 7'd0;
        rt_next_s    = round_time;
        frame_wrap_s = (frame_cnt_r == FRAME_LAST);
        if (round_time == 7'd0) begin
            rt_dec_s = 7'd0;
        end else begin
            rt_dec_s = round_time - 7'd1;
        end
        if (frame_wrap_s) begin
            rt_next_s = rt_dec_s;
        end else begin
            rt_next_s = round_time;
        end
        ko_s        = (hp1 == 8'd0) || (hp2 == 8'd0);
        round_end_s = ko_s || (rt_next_s == 7'd0);
        // KO rules take priority over a simultaneous timeout.
        if (ko_s) begin
            end_winner_s = ko_winner(hp1, hp2);
        end else begin
            end_winner_s = timeout_winner(hp1, hp2);
        end
    end

    // Previous-cycle start-key match, loaded every cycle including Reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_prev_r <= 1'b0;
        end else begin
            key_prev_r <= key_match_s;
        end
    end

    // Match-flow FSM with registered requests, countdown and winner.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r      <= ST_IDLE;
            game_start   <= 1'b0;
            game_over    <= 1'b0;
            game_restart <= 1'b0;
            round_time   <= ROUND_INIT;
            winner       <= 2'd0;
            frame_cnt_r  <= FRAME_ZERO;
            lockout_r    <= LOCK_ZERO;
        end else if (gs_start_s && (state_r != ST_IDLE) && (state_r != ST_START_REQ)) begin
            // Controller fell back to start: drop everything and resync.
            // START_REQ is excluded because start is the state it waits in.
            state_r      <= ST_IDLE;
            game_start   <= 1'b0;
            game_over    <= 1'b0;
            game_restart <= 1'b0;
            round_time   <= ROUND_INIT;
            winner       <= 2'd0;
            frame_cnt_r  <= FRAME_ZERO;
            lockout_r    <= LOCK_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    game_over    <= 1'b0;
                    game_restart <= 1'b0;
                    round_time   <= ROUND_INIT;
                    winner       <= 2'd0;
                    frame_cnt_r  <= FRAME_ZERO;
                    if (key_hit_s) begin
                        game_start <= 1'b1;
                        state_r    <= ST_START_REQ;
                    end else begin
                        game_start <= 1'b0;
                    end
                end
                ST_START_REQ: begin
                    if (gs_game_s) begin
                        game_start <= 1'b0;
                        state_r    <= ST_FIGHT;
                    end
                end
                ST_FIGHT: begin
                    if (frame_tick) begin
                        if (frame_wrap_s) begin
                            frame_cnt_r <= FRAME_ZERO;
                        end else begin
                            frame_cnt_r <= frame_cnt_r + FRAME_ONE;
                        end
                        round_time <= rt_next_s;
                        if (round_end_s) begin
                            winner    <= end_winner_s;
                            game_over <= 1'b1;
                            state_r   <= ST_OVER_REQ;
                        end
                    end
                end
                ST_OVER_REQ: begin
                    if (gs_over_s) begin
                        game_over <= 1'b0;
                        lockout_r <= LOCK_INIT;
                        state_r   <= ST_LOCKOUT;
                    end
                end
                ST_LOCKOUT: begin
                    // A zero lockout length passes straight through.
                    if (lockout_r == LOCK_ZERO) begin
                        state_r <= ST_READY;
                    end else if (frame_tick) begin
                        lockout_r <= lockout_r - LOCK_ONE;
                        if (lockout_r == LOCK_ONE) begin
                            state_r <= ST_READY;
                        end
                    end
                end
                ST_READY: begin
                    if (key_hit_s) begin
                        game_restart <= 1'b1;
                        round_time   <= ROUND_INIT;
                        frame_cnt_r  <= FRAME_ZERO;
                        winner       <= 2'd0;
                        state_r      <= ST_RESTART_REQ;
                    end
                end
                ST_RESTART_REQ: begin
                    if (gs_game_s) begin
                        game_restart <= 1'b0;
                        state_r      <= ST_FIGHT;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    game_start   <= 1'b0;
                    game_over    <= 1'b0;
                    game_restart <= 1'b0;
                    round_time   <= ROUND_INIT;
                    winner       <= 2'd0;
                    frame_cnt_r  <= FRAME_ZERO;
                    lockout_r    <= LOCK_ZERO;
                end
            endcase
        end
    end

endmodule
